bitstream_serializer: RTL and testbench
=======================================

BITSTREAM_SERIALIZER -- requirements
Module: bitstream_serializer

Interface
REQ-001 Parameter DATA_W, default 8: width of each parallel input word, in bits (valid range 2..32).
REQ-002 Parameter MSB_FIRST, default 1: 1 sends in_data[DATA_W-1] first; 0 sends in_data[0] first.
REQ-003 Parameter DIV_W, default 8: width of the bit-period divider input.
REQ-004 clk  input  1  clock; all state changes occur on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 div  input  DIV_W  bit period minus one, in clk cycles (0 = one bit per cycle).
REQ-007 in_data  input  DATA_W  parallel word to serialize.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  the block can accept a word this cycle.
REQ-010 bit_out  output  1  current serial bit; feeds the downstream sequence detector's serial input.
REQ-011 bit_stb  output  1  one-cycle strobe marking the first cycle of each bit period.
REQ-012 last  output  1  asserted with bit_stb on the final bit of a word.
REQ-013 busy  output  1  a word is held or being shifted.

Function
REQ-014 A word is accepted on a rising edge where in_valid && in_ready is true; it is written into a 1-entry holding register (hold_valid=1).
REQ-015 in_ready SHALL equal !hold_valid (registered-state based, no combinational path from in_valid).
REQ-016 The state machine has two states: IDLE and SHIFT.
REQ-017 IDLE with hold_valid=1: on the next edge, load the shifter from the holding register, clear hold_valid, capture div into the period counter, set bit index 0, and enter SHIFT.
REQ-018 SHIFT: bit_out presents the current bit for div+1 cycles; bit_stb is high only in the first of those cycles.
REQ-019 Latency: for a word accepted at edge N from IDLE, the first bit_stb is high in the cycle following edge N+1.
REQ-020 Ending a bit period (period counter = 0) advances the bit index and reloads the counter from div; a change to div takes effect only at the next bit boundary.
REQ-021 The final bit period ends when period counter = 0 and bit index = DATA_W-1. With hold_valid=1, the next word loads on that edge with no idle cycle between words. Otherwise the machine returns to IDLE.
REQ-022 The holding register may be written on the same edge on which its contents transfer to the shifter only if in_ready was high in that cycle; no word is ever dropped or duplicated.
REQ-023 In IDLE: bit_out=0, bit_stb=0, last=0.
REQ-024 busy = (state==SHIFT) || hold_valid.
REQ-025 With div=0 and a continuously supplied stream, bit_stb stays high continuously and one bit is emitted per cycle.

Reset
REQ-026 While rst is high: state=IDLE, hold_valid=0, shifter=0, bit index=0, period counter=0, bit_out=0, bit_stb=0, last=0, busy=0, in_ready=1.
REQ-027 Words presented while rst is high are not accepted.
REQ-028 Reset asserted mid-word discards the partial word and any held word; no further bit_stb occurs until a new word is accepted after reset deassertion.

Verification
REQ-029 DATA_W=8, MSB_FIRST=1, div=0, single word 0x0A -> 8 consecutive strobes with bit_out 0,0,0,0,1,0,1,0; last high on the 8th only; then IDLE with busy=0.
REQ-030 MSB_FIRST=0, div=0, word 0x0A -> bit_out 0,1,0,1,0,0,0,0.
REQ-031 div=2, words 0xA5 then 0x3C back-to-back -> 16 strobes spaced exactly 3 cycles apart, no gap at the word boundary, last on strobes 8 and 16.
REQ-032 in_valid held high with 3 words queued, div=0 -> in_ready low while the holding register is full; all 3 words emitted in order; in_ready rises exactly on the transfer edges.
REQ-033 rst pulsed after the 3rd strobe of word 0xFF -> outputs take reset values immediately; no further strobes; a subsequent word 0x81 serializes correctly from bit 0.
REQ-034 div changed from 0 to 3 mid-word -> the current bit keeps its period; the following bits last 4 cycles each.

Source files
------------

// File: rtl/bitstream_serializer.sv
// Parallel-to-serial converter with a one-word holding register and a
// programmable bit period. Each bit is presented for div+1 clk cycles, with a
// one-cycle strobe at the start of every bit period.
module bitstream_serializer #(
   parameter int DATA_W    = 8,
   parameter int MSB_FIRST = 1,
   parameter int DIV_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIV_W-1:0]  div,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              bit_out,
   output logic              bit_stb,
   output logic              last,
   output logic              busy
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t            state_q, state_d;
   logic              hold_valid_q, hold_valid_d;
   logic [DATA_W-1:0] hold_data_q, hold_data_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic              bit_out_q, bit_out_d;
   logic              bit_stb_q, bit_stb_d;
   logic              last_q, last_d;
   logic              load;

   // Bit that goes on the line first for a given shifter content.
   function automatic logic head_bit(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
   endfunction

   // Shifter content after the current head bit has been sent.
   function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
      return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
   endfunction

   // Next-state logic: bit period timing, word hand-off and holding register.
   always_comb begin
      state_d      = state_q;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      shift_d      = shift_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      bit_out_d    = bit_out_q;
      bit_stb_d    = 1'b0;
      last_d       = 1'b0;
      load         = 1'b0;

      case (state_q)
         IDLE: begin
            bit_out_d = 1'b0;
            if (hold_valid_q) begin
               load = 1'b1;
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (idx_q != IDX_LAST) begin
               shift_d   = advance(shift_q);
               idx_d     = idx_q + 1'b1;
               cnt_d     = div;
               bit_out_d = head_bit(advance(shift_q));
               bit_stb_d = 1'b1;
               last_d    = ((idx_q + 1'b1) == IDX_LAST);
            end else if (hold_valid_q) begin
               load = 1'b1;
            end else begin
               state_d   = IDLE;
               shift_d   = '0;
               idx_d     = '0;
               cnt_d     = '0;
               bit_out_d = 1'b0;
            end
         end
      endcase

      // Transfer and accept can never coincide: accept needs an empty holding
      // register, transfer needs a full one, so no word is lost or repeated.
      if (load) begin
         state_d      = SHIFT;
         shift_d      = hold_data_q;
         idx_d        = '0;
         cnt_d        = div;
         bit_out_d    = head_bit(hold_data_q);
         bit_stb_d    = 1'b1;
         last_d       = 1'b0;
         hold_valid_d = 1'b0;
      end

      if (in_valid && !hold_valid_q) begin
         hold_valid_d = 1'b1;
         hold_data_d  = in_data;
      end
   end

   // State and registered outputs, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         shift_q      <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         bit_out_q    <= 1'b0;
         bit_stb_q    <= 1'b0;
         last_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         shift_q      <= shift_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         bit_out_q    <= bit_out_d;
         bit_stb_q    <= bit_stb_d;
         last_q       <= last_d;
      end
   end

   assign in_ready = !hold_valid_q;
   assign busy     = (state_q == SHIFT) || hold_valid_q;
   assign bit_out  = bit_out_q;
   assign bit_stb  = bit_stb_q;
   assign last     = last_q;

endmodule

// File: tb/tb_bitstream_serializer.sv
// Bench for bitstream_serializer: an MSB-first and an LSB-first instance share
// one stimulus stream and are checked every cycle against a queue-based model,
// plus directed checks on the logged strobe sequence.
module tb_bitstream_serializer;

   localparam int DW = 8;

   logic          clk      = 1'b0;
   logic          rst      = 1'b0;
   logic [7:0]    div      = '0;
   logic [DW-1:0] in_data  = '0;
   logic          in_valid = 1'b0;

   logic rdy_m, bit_m, stb_m, last_m, busy_m;
   logic rdy_l, bit_l, stb_l, last_l, busy_l;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: bit queues for the word on the line, a held word and a
   // count of cycles left in the current bit period.
   logic       m_act = 1'b0;
   logic       m_hv  = 1'b0;
   logic [7:0] m_hold = '0;
   int         m_rem = 0;
   logic       e_stb = 1'b0;
   logic       mq[$];
   logic       lq[$];

   // Strobe log used by the directed checks.
   int   lg_cyc[$];
   logic lg_m[$];
   logic lg_l[$];
   logic lg_last[$];

   bitstream_serializer #(.DATA_W(DW), .MSB_FIRST(1), .DIV_W(8)) dut_m (
      .clk(clk), .rst(rst), .div(div), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_m), .bit_out(bit_m), .bit_stb(stb_m), .last(last_m), .busy(busy_m)
   );

   bitstream_serializer #(.DATA_W(DW), .MSB_FIRST(0), .DIV_W(8)) dut_l (
      .clk(clk), .rst(rst), .div(div), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_l), .bit_out(bit_l), .bit_stb(stb_l), .last(last_l), .busy(busy_l)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_act = 1'b0; m_hv = 1'b0; m_hold = '0; m_rem = 0; e_stb = 1'b0;
      mq.delete(); lq.delete();
   endtask

   task automatic model_load(input logic [7:0] w);
      mq.delete(); lq.delete();
      for (int i = 0; i < DW; i++) begin
         mq.push_back(w[DW-1-i]);
         lq.push_back(w[i]);
      end
      m_act = 1'b1; m_rem = int'(div); e_stb = 1'b1; m_hv = 1'b0;
   endtask

   task automatic model_edge();
      logic acc;
      if (rst) begin
         model_reset();
         return;
      end
      acc   = in_valid && !m_hv;
      e_stb = 1'b0;
      if (!m_act) begin
         if (m_hv) model_load(m_hold);
      end else if (m_rem > 0) begin
         m_rem--;
      end else begin
         void'(mq.pop_front());
         void'(lq.pop_front());
         if (mq.size() > 0) begin
            m_rem = int'(div);
            e_stb = 1'b1;
         end else if (m_hv) begin
            model_load(m_hold);
         end else begin
            m_act = 1'b0;
         end
      end
      if (acc) begin
         m_hv   = 1'b1;
         m_hold = in_data;
      end
   endtask

   task automatic cycle();
      logic eb_m, eb_l, e_last;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
      eb_m   = m_act ? mq[0] : 1'b0;
      eb_l   = m_act ? lq[0] : 1'b0;
      e_last = e_stb && (mq.size() == 1);
      chk("stb_m", stb_m, e_stb);
      chk("stb_l", stb_l, e_stb);
      chk("bit_m", bit_m, eb_m);
      chk("bit_l", bit_l, eb_l);
      chk("last_m", last_m, e_last);
      chk("last_l", last_l, e_last);
      chk("ready_m", rdy_m, !m_hv);
      chk("ready_l", rdy_l, !m_hv);
      chk("busy_m", busy_m, m_act || m_hv);
      chk("busy_l", busy_l, m_act || m_hv);
      if (stb_m === 1'b1) begin
         lg_cyc.push_back(cyc);
         lg_m.push_back(bit_m);
         lg_l.push_back(bit_l);
         lg_last.push_back(last_m);
      end
   endtask

   task automatic clear_log();
      lg_cyc.delete(); lg_m.delete(); lg_l.delete(); lg_last.delete();
   endtask

   task automatic apply_reset(input int n);
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_bit_m", bit_m, 1'b0);
      chk("rst_bit_l", bit_l, 1'b0);
      chk("rst_stb_m", stb_m, 1'b0);
      chk("rst_last_m", last_m, 1'b0);
      chk("rst_busy_m", busy_m, 1'b0);
      chk("rst_busy_l", busy_l, 1'b0);
      chk("rst_ready_m", rdy_m, 1'b1);
      chk("rst_ready_l", rdy_l, 1'b1);
      repeat (n) cycle();
      rst = 1'b0;
   endtask

   // Presents a word and returns after the edge that accepts it; in_valid stays high.
   task automatic push_word(input logic [7:0] w);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = w;
      while (rdy_m !== 1'b1 && n < 100) begin
         cycle();
         n++;
      end
      chk("push_wait_ready", rdy_m, 1'b1);
      cycle();
   endtask

   task automatic wait_idle(input int max_c);
      int n;
      n = 0;
      while (busy_m === 1'b1 && n < max_c) begin
         cycle();
         n++;
      end
      chk("idle_wait", busy_m, 1'b0);
      cycle();
   endtask

   task automatic wait_strobes(input int k, input int max_c);
      int n;
      n = 0;
      while (lg_cyc.size() < k && n < max_c) begin
         cycle();
         n++;
      end
      chk("strobe_wait", lg_cyc.size(), k);
   endtask

   function automatic logic [31:0] log_bits(input bit lsb);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < lg_m.size(); i++) v = {v[30:0], lsb ? lg_l[i] : lg_m[i]};
      return v;
   endfunction

   function automatic logic [31:0] last_mask();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < lg_last.size() && i < 32; i++) v[i] = lg_last[i];
      return v;
   endfunction

   function automatic int bad_gaps(input int from, input int g);
      int n;
      n = 0;
      for (int i = from + 1; i < lg_cyc.size(); i++)
         if (lg_cyc[i] - lg_cyc[i-1] != g) n++;
      return n;
   endfunction

   function automatic logic [7:0] rev8(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return r;
   endfunction

   initial begin
      int         c_acc;
      logic [7:0] w0, w1, w2;

      // Reset, with a word offered while reset is high.
      #2;
      in_valid = 1'b1;
      in_data  = 8'h55;
      apply_reset(3);
      in_valid = 1'b0;
      cycle();
      chk("rst_no_accept", busy_m, 1'b0);

      // Single word 0x0A, div=0, both bit orders.
      clear_log();
      div      = 8'd0;
      in_valid = 1'b1;
      in_data  = 8'h0A;
      cycle();
      c_acc    = cyc;
      in_valid = 1'b0;
      wait_idle(40);
      chk("w0a_count", lg_cyc.size(), 8);
      chk("w0a_latency", lg_cyc[0], c_acc + 1);
      chk("w0a_gaps", bad_gaps(0, 1), 0);
      chk("w0a_bits_msb", log_bits(1'b0), 32'h0A);
      chk("w0a_bits_lsb", log_bits(1'b1), 32'h50);
      chk("w0a_last", last_mask(), 32'h80);

      // Back-to-back words with div=2.
      clear_log();
      div = 8'd2;
      push_word(8'hA5);
      push_word(8'h3C);
      in_valid = 1'b0;
      wait_idle(100);
      chk("b2b_count", lg_cyc.size(), 16);
      chk("b2b_gaps", bad_gaps(0, 3), 0);
      chk("b2b_bits_msb", log_bits(1'b0), 32'hA53C);
      chk("b2b_bits_lsb", log_bits(1'b1), {16'h0, rev8(8'hA5), rev8(8'h3C)});
      chk("b2b_last", last_mask(), 32'h8080);

      // Three random words streamed with in_valid held high, div=0.
      clear_log();
      div = 8'd0;
      w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
      push_word(w0);
      push_word(w1);
      push_word(w2);
      in_valid = 1'b0;
      wait_idle(60);
      chk("stream_count", lg_cyc.size(), 24);
      chk("stream_gaps", bad_gaps(0, 1), 0);
      chk("stream_bits_msb", log_bits(1'b0), {8'h0, w0, w1, w2});
      chk("stream_bits_lsb", log_bits(1'b1), {8'h0, rev8(w0), rev8(w1), rev8(w2)});
      chk("stream_last", last_mask(), 32'h808080);

      // Reset mid-word, then a fresh word.
      clear_log();
      push_word(8'hFF);
      in_valid = 1'b0;
      wait_strobes(3, 20);
      apply_reset(2);
      clear_log();
      repeat (5) cycle();
      chk("post_rst_no_stb", lg_cyc.size(), 0);
      push_word(8'h81);
      in_valid = 1'b0;
      wait_idle(40);
      chk("w81_count", lg_cyc.size(), 8);
      chk("w81_bits_msb", log_bits(1'b0), 32'h81);
      chk("w81_bits_lsb", log_bits(1'b1), 32'h81);

      // div changed from 0 to 3 after the second bit strobe.
      clear_log();
      div = 8'd0;
      w0 = 8'($urandom);
      push_word(w0);
      in_valid = 1'b0;
      wait_strobes(2, 20);
      div = 8'd3;
      wait_idle(100);
      chk("div_count", lg_cyc.size(), 8);
      chk("div_gap1", lg_cyc[1] - lg_cyc[0], 1);
      chk("div_gap2", lg_cyc[2] - lg_cyc[1], 1);
      chk("div_gaps_rest", bad_gaps(2, 4), 0);
      chk("div_bits_msb", log_bits(1'b0), {24'h0, w0});

      // Random traffic with occasional div changes and one reset.
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_data  = 8'($urandom);
         if ($urandom_range(0, 15) == 0) div = 8'($urandom_range(0, 3));
         if (i == 250) apply_reset(1);
         else cycle();
      end
      in_valid = 1'b0;
      wait_idle(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
